// File: rtl/leiwand_rv32_wb_arbiter_pkg.sv
// Shared definitions for the leiwand_rv32 Wishbone arbiter slice:
// arbiter state / grant encoding, master indices and default memory map.
package leiwand_rv32_wb_arbiter_pkg;

  localparam int unsigned DEF_MEM_WIDTH      = 32;
  localparam logic [31:0] DEF_S0_BASE        = 32'h1000_0000;  // internal SRAM
  localparam int unsigned DEF_S0_WORDS       = 1024;
  localparam logic [31:0] DEF_S1_BASE        = 32'h2000_0000;  // ROM
  localparam int unsigned DEF_S1_WORDS       = 1024;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  // State encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_GRANT0 = 2'b01,
    ST_GRANT1 = 2'b10
  } arb_state_t;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/leiwand_rv32_wb_decoder.sv
// Combinational address window decoder for the shared slave bus.
// Ports: stb/addr from the granted master; s0_stb/s1_stb per-slave strobes;
// unmapped flags a strobe that hits neither window.
module leiwand_rv32_wb_decoder
  import leiwand_rv32_wb_arbiter_pkg::*;
#(
  parameter int unsigned          MEM_WIDTH = DEF_MEM_WIDTH,
  parameter logic [MEM_WIDTH-1:0] S0_BASE   = MEM_WIDTH'(DEF_S0_BASE),
  parameter int unsigned          S0_WORDS  = DEF_S0_WORDS,
  parameter logic [MEM_WIDTH-1:0] S1_BASE   = MEM_WIDTH'(DEF_S1_BASE),
  parameter int unsigned          S1_WORDS  = DEF_S1_WORDS
) (
  input  logic                 stb,
  input  logic [MEM_WIDTH-1:0] addr,
  output logic                 s0_stb,
  output logic                 s1_stb,
  output logic                 unmapped
);

  // One extra bit so a window ending exactly at the top of the space does not wrap.
  localparam int unsigned AW = MEM_WIDTH + 1;
  localparam logic [AW-1:0] S0_LO = AW'(S0_BASE);
  localparam logic [AW-1:0] S0_HI = AW'(S0_BASE) + (AW'(S0_WORDS) << 2);
  localparam logic [AW-1:0] S1_LO = AW'(S1_BASE);
  localparam logic [AW-1:0] S1_HI = AW'(S1_BASE) + (AW'(S1_WORDS) << 2);

  logic [AW-1:0] addr_x;
  logic          hit0;
  logic          hit1;

  assign addr_x   = {1'b0, addr};
  assign hit0     = (addr_x >= S0_LO) && (addr_x < S0_HI);
  assign hit1     = (addr_x >= S1_LO) && (addr_x < S1_HI);
  assign s0_stb   = stb && hit0;
  assign s1_stb   = stb && hit1;
  assign unmapped = stb && !hit0 && !hit1;

endmodule

// File: rtl/leiwand_rv32_wb_arbiter.sv
// Two-master pipelined Wishbone arbiter with SRAM/ROM window decode.
// Round-robin between m0 (CPU) and m1 (DMA/loader); a master keeps the grant
// while its cyc is high. Unmapped strobes are acked one cycle later with 0 data.
// Ports: clk, reset (async, active-high); m0_*/m1_* master sides; s_* shared
// slave request; s0_*/s1_* per-slave strobe and response; grant one-hot owner.
// Optional: define LEIWAND_RV32_WB_ARB_TIMEOUT_EN to add a no-ack watchdog that
// pulses mN_err and drops the grant after TIMEOUT_CYCLES.
// Slaves are expected to ack at least one cycle after accepting a strobe.
module leiwand_rv32_wb_arbiter
  import leiwand_rv32_wb_arbiter_pkg::*;
#(
  parameter int unsigned          MEM_WIDTH      = DEF_MEM_WIDTH,
  parameter logic [MEM_WIDTH-1:0] S0_BASE        = MEM_WIDTH'(DEF_S0_BASE),
  parameter int unsigned          S0_WORDS       = DEF_S0_WORDS,
  parameter logic [MEM_WIDTH-1:0] S1_BASE        = MEM_WIDTH'(DEF_S1_BASE),
  parameter int unsigned          S1_WORDS       = DEF_S1_WORDS,
  parameter int unsigned          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_cyc,
  input  logic                 m0_stb,
  input  logic                 m0_we,
  input  logic [MEM_WIDTH-1:0] m0_addr,
  input  logic [MEM_WIDTH-1:0] m0_data_out,
  output logic [MEM_WIDTH-1:0] m0_data_in,
  output logic                 m0_ack,
  output logic                 m0_stall,
  output logic                 m0_err,
  input  logic                 m1_cyc,
  input  logic                 m1_stb,
  input  logic                 m1_we,
  input  logic [MEM_WIDTH-1:0] m1_addr,
  input  logic [MEM_WIDTH-1:0] m1_data_out,
  output logic [MEM_WIDTH-1:0] m1_data_in,
  output logic                 m1_ack,
  output logic                 m1_stall,
  output logic                 m1_err,
  output logic                 s_cyc,
  output logic                 s_we,
  output logic [MEM_WIDTH-1:0] s_addr,
  output logic [MEM_WIDTH-1:0] s_data_out,
  output logic                 s0_stb,
  input  logic [MEM_WIDTH-1:0] s0_data_in,
  input  logic                 s0_ack,
  input  logic                 s0_stall,
  output logic                 s1_stb,
  input  logic [MEM_WIDTH-1:0] s1_data_in,
  input  logic                 s1_ack,
  input  logic                 s1_stall,
  output logic [1:0]           grant
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_t           state;
  logic                 last;          // most recently granted master
  logic                 unmapped_ack;
  logic                 ack_tag;       // master that issued the last accepted strobe
  logic                 g_valid;
  logic                 g_idx;
  logic                 g_cyc;
  logic                 g_stb;
  logic                 g_we;
  logic [MEM_WIDTH-1:0] g_addr;
  logic [MEM_WIDTH-1:0] g_data;
  logic                 unmapped;
  logic                 slave_stall;
  logic                 resp_ack;
  logic [MEM_WIDTH-1:0] resp_data;
  logic                 wd_hit;

  assign g_valid = (state != ST_IDLE);
  assign g_idx   = (state == ST_GRANT1);
  assign grant   = 2'(state);

  // Request mux from the granted master; everything 0 when idle.
  always_comb begin
    g_cyc  = 1'b0;
    g_stb  = 1'b0;
    g_we   = 1'b0;
    g_addr = '0;
    g_data = '0;
    case (state)
      ST_GRANT0: begin
        g_cyc  = m0_cyc;
        g_stb  = m0_stb;
        g_we   = m0_we;
        g_addr = m0_addr;
        g_data = m0_data_out;
      end
      ST_GRANT1: begin
        g_cyc  = m1_cyc;
        g_stb  = m1_stb;
        g_we   = m1_we;
        g_addr = m1_addr;
        g_data = m1_data_out;
      end
      default: ;
    endcase
  end

  assign s_cyc      = g_cyc;
  assign s_we       = g_we;
  assign s_addr     = g_addr;
  assign s_data_out = g_data;

  leiwand_rv32_wb_decoder #(
    .MEM_WIDTH (MEM_WIDTH),
    .S0_BASE   (S0_BASE),
    .S0_WORDS  (S0_WORDS),
    .S1_BASE   (S1_BASE),
    .S1_WORDS  (S1_WORDS)
  ) u_decoder (
    .stb      (g_stb),
    .addr     (g_addr),
    .s0_stb   (s0_stb),
    .s1_stb   (s1_stb),
    .unmapped (unmapped)
  );

  // Acks belonging to a previous owner (stale tag) or arriving while idle are dropped.
  assign slave_stall = s0_stall | s1_stall;
  assign resp_ack    = g_valid && (ack_tag == g_idx) && (s0_ack | s1_ack | unmapped_ack);
  assign resp_data   = s0_data_in | s1_data_in;

  // Response demux: the non-granted master sees a stalled, silent bus.
  always_comb begin
    m0_ack     = 1'b0;
    m0_stall   = 1'b1;
    m0_data_in = '0;
    m1_ack     = 1'b0;
    m1_stall   = 1'b1;
    m1_data_in = '0;
    case (state)
      ST_GRANT0: begin
        m0_ack     = resp_ack;
        m0_stall   = slave_stall;
        m0_data_in = resp_data;
      end
      ST_GRANT1: begin
        m1_ack     = resp_ack;
        m1_stall   = slave_stall;
        m1_data_in = resp_data;
      end
      default: ;
    endcase
  end

`ifdef LEIWAND_RV32_WB_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic [1:0]      err_q;

  assign wd_hit = g_cyc && !resp_ack && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // No-ack watchdog; err is a one-cycle pulse to the owner at timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= '0;
    end else begin
      err_q <= '0;
      if (!g_cyc || resp_ack || wd_hit) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (wd_hit) begin
        err_q <= 2'(state);
      end
    end
  end

  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
`else
  assign wd_hit = 1'b0;
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  // Arbiter FSM, round-robin pointer, unmapped responder and ack ownership tag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      last         <= MASTER1;
      unmapped_ack <= 1'b0;
      ack_tag      <= MASTER0;
    end else begin
      unmapped_ack <= unmapped && !slave_stall;
      if (g_stb && !slave_stall) begin
        ack_tag <= g_idx;
      end
      if (wd_hit) begin
        state <= ST_IDLE;
        last  <= g_idx;
      end else begin
        case (state)
          ST_IDLE: begin
            if (m0_cyc && (!m1_cyc || last == MASTER1)) begin
              state <= ST_GRANT0;
              last  <= MASTER0;
            end else if (m1_cyc) begin
              state <= ST_GRANT1;
              last  <= MASTER1;
            end
          end
          ST_GRANT0: begin
            if (!m0_cyc) begin
              if (m1_cyc) begin
                state <= ST_GRANT1;
                last  <= MASTER1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_GRANT1: begin
            if (!m1_cyc) begin
              if (m0_cyc) begin
                state <= ST_GRANT0;
                last  <= MASTER0;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_leiwand_rv32_wb_arbiter.sv
// Directed bench for leiwand_rv32_wb_arbiter with simple 1-cycle slave models.
module tb_leiwand_rv32_wb_arbiter;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         m0_cyc, m0_stb, m0_we;
  logic [W-1:0] m0_addr, m0_data_out, m0_data_in;
  logic         m0_ack, m0_stall, m0_err;
  logic         m1_cyc, m1_stb, m1_we;
  logic [W-1:0] m1_addr, m1_data_out, m1_data_in;
  logic         m1_ack, m1_stall, m1_err;
  logic         s_cyc, s_we;
  logic [W-1:0] s_addr, s_data_out;
  logic         s0_stb, s1_stb;
  logic [W-1:0] s0_data_in = '0;
  logic [W-1:0] s1_data_in = '0;
  logic         s0_ack = 1'b0;
  logic         s1_ack = 1'b0;
  logic         s0_stall = 1'b0;
  logic         s1_stall = 1'b0;
  logic [1:0]   grant;
  logic         mute = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] rom_exp [3] = '{32'hE3C3_0000, 32'hE3C3_0004, 32'hE3C3_0008};

  always #5 clk = ~clk;

  leiwand_rv32_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_data_out(m0_data_out), .m0_data_in(m0_data_in),
    .m0_ack(m0_ack), .m0_stall(m0_stall), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_data_out(m1_data_out), .m1_data_in(m1_data_in),
    .m1_ack(m1_ack), .m1_stall(m1_stall), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr), .s_data_out(s_data_out),
    .s0_stb(s0_stb), .s0_data_in(s0_data_in), .s0_ack(s0_ack), .s0_stall(s0_stall),
    .s1_stb(s1_stb), .s1_data_in(s1_data_in), .s1_ack(s1_ack), .s1_stall(s1_stall),
    .grant(grant)
  );

  // Slave models: ack one cycle after the strobe, read data = addr ^ per-slave key.
  always @(posedge clk) begin
    s0_ack     <= s0_stb && !mute;
    s0_data_in <= (s0_stb && !mute) ? (s_addr ^ 32'h5A5A_0000) : '0;
    s1_ack     <= s1_stb && !mute;
    s1_data_in <= (s1_stb && !mute) ? (s_addr ^ 32'hC3C3_0000) : '0;
  end

  task automatic idle_masters();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_data_out = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_data_out = '0;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    reset = 1'b1;
    idle_masters();
    repeat (2) @(negedge clk);
    got = {grant, s_cyc, s_we, s0_stb, s1_stb, m0_ack, m1_ack, m0_err, m1_err, m0_stall, m1_stall};
    tests++;
    if (got !== 12'b00_0000_0000_11) begin
      fails++; $display("FAIL reset_ctrl got %b want %b", got, 12'b00_0000_0000_11);
    end
    tests++;
    if ({s_addr, s_data_out, m0_data_in, m1_data_in} !== '0) begin
      fails++; $display("FAIL reset_data got %h %h %h %h want 0", s_addr, s_data_out, m0_data_in, m1_data_in);
    end
    reset = 1'b0;
  endtask

  task automatic test_sram_read();
    @(negedge clk);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h1000_0004;
    #1;
    tests++;
    if (grant !== 2'b00 || m0_stall !== 1'b1) begin
      fails++; $display("FAIL sram_pregrant grant %b stall %b want 00 1", grant, m0_stall);
    end
    @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL sram_grant got %b want 01", grant); end
    tests++;
    if ({s0_stb, s1_stb, s_cyc, m0_stall, m1_stall} !== 5'b10101) begin
      fails++; $display("FAIL sram_route got %b want 10101", {s0_stb, s1_stb, s_cyc, m0_stall, m1_stall});
    end
    tests++;
    if (s_addr !== 32'h1000_0004) begin fails++; $display("FAIL sram_addr got %h want 10000004", s_addr); end
    @(negedge clk);
    tests++;
    if (m0_ack !== 1'b1 || m0_data_in !== 32'h4A5A_0004 || m1_stall !== 1'b1) begin
      fails++; $display("FAIL sram_resp ack %b data %h m1_stall %b want 1 4a5a0004 1", m0_ack, m0_data_in, m1_stall);
    end
    m0_stb = 1'b0;
    @(negedge clk);
    tests++;
    if (m0_ack !== 1'b0) begin fails++; $display("FAIL sram_single_ack got %b want 0", m0_ack); end
    m0_cyc = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL sram_release got %b want 00", grant); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL rr_first_tie got %b want 01", grant); end
    m0_cyc = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 2'b10) begin fails++; $display("FAIL rr_handover got %b want 10", grant); end
    m1_cyc = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL rr_idle got %b want 00", grant); end
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL rr_second_tie got %b want 01", grant); end
    idle_masters();
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h2000_0000;
    @(negedge clk);
    tests++;
    if (grant !== 2'b10 || s1_stb !== 1'b1) begin
      fails++; $display("FAIL b2b_grant grant %b s1_stb %b want 10 1", grant, s1_stb);
    end
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h1000_0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (m1_ack !== 1'b1 || m1_data_in !== rom_exp[i]) begin
        fails++; $display("FAIL b2b_ack%0d ack %b data %h want 1 %h", i, m1_ack, m1_data_in, rom_exp[i]);
      end
      tests++;
      if (m0_stall !== 1'b1 || m0_ack !== 1'b0) begin
        fails++; $display("FAIL b2b_m0_blocked%0d stall %b ack %b want 1 0", i, m0_stall, m0_ack);
      end
      if (i < 2) m1_addr = m1_addr + 32'd4;
      else m1_stb = 1'b0;
    end
    m1_cyc = 1'b0;
    @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL b2b_handover got %b want 01", grant); end
    idle_masters();
    @(negedge clk);
    tests++;
    if (grant !== 2'b00) begin fails++; $display("FAIL b2b_release got %b want 00", grant); end
  endtask

  task automatic test_unmapped();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h3000_0000;
    @(negedge clk);
    tests++;
    if ({grant, s0_stb, s1_stb, m0_stall, m0_ack} !== 6'b01_0000) begin
      fails++; $display("FAIL unmapped_req got %b want 010000", {grant, s0_stb, s1_stb, m0_stall, m0_ack});
    end
    @(negedge clk);
    tests++;
    if (m0_ack !== 1'b1 || m0_data_in !== '0) begin
      fails++; $display("FAIL unmapped_ack ack %b data %h want 1 0", m0_ack, m0_data_in);
    end
    m0_addr = 32'h1000_0FFC;
    #1;
    tests++;
    if (s0_stb !== 1'b1) begin fails++; $display("FAIL win0_last_word s0_stb %b want 1", s0_stb); end
    m0_addr = 32'h1000_1000;
    #1;
    tests++;
    if ({s0_stb, s1_stb} !== 2'b00) begin fails++; $display("FAIL win0_upper_excl got %b want 00", {s0_stb, s1_stb}); end
    m0_addr = 32'h0FFF_FFFC;
    #1;
    tests++;
    if ({s0_stb, s1_stb} !== 2'b00) begin fails++; $display("FAIL win0_below_base got %b want 00", {s0_stb, s1_stb}); end
    m0_addr = 32'h2000_0FFC;
    #1;
    tests++;
    if ({s0_stb, s1_stb} !== 2'b01) begin fails++; $display("FAIL win1_last_word got %b want 01", {s0_stb, s1_stb}); end
    m0_stb = 1'b0;
    @(negedge clk);
    m0_cyc = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_inflight();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_addr = 32'h2000_0010;
    @(negedge clk);
    tests++;
    if (grant !== 2'b10) begin fails++; $display("FAIL inflight_grant got %b want 10", grant); end
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if ({grant, s_cyc, m1_ack, m1_stall} !== 5'b00_001) begin
      fails++; $display("FAIL inflight_reset got %b want 00001", {grant, s_cyc, m1_ack, m1_stall});
    end
    idle_masters();
    @(negedge clk);
    reset = 1'b0;
    m0_cyc = 1'b1; m1_cyc = 1'b1;
    @(negedge clk);
    tests++;
    if (grant !== 2'b01) begin fails++; $display("FAIL inflight_next_tie got %b want 01", grant); end
    idle_masters();
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int         err_cnt;
    int         err_at;
    logic [1:0] grant_at_err;
    err_cnt = 0;
    err_at = -1;
    grant_at_err = 2'bxx;
    mute = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_addr = 32'h1000_0000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (m0_err === 1'b1) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = c;
          grant_at_err = grant;
        end
      end
    end
`ifdef LEIWAND_RV32_WB_ARB_TIMEOUT_EN
    tests++;
    if (err_cnt != 1 || err_at != 17) begin
      fails++; $display("FAIL timeout_err pulses %0d at %0d want 1 at 17", err_cnt, err_at);
    end
    tests++;
    if (grant_at_err !== 2'b00) begin fails++; $display("FAIL timeout_grant got %b want 00", grant_at_err); end
`else
    tests++;
    if (err_cnt != 0) begin fails++; $display("FAIL no_timeout_err pulses %0d want 0", err_cnt); end
    tests++;
    if (grant !== 2'b01 || m1_err !== 1'b0) begin
      fails++; $display("FAIL no_timeout_hold grant %b m1_err %b want 01 0", grant, m1_err);
    end
`endif
    idle_masters();
    mute = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_sram_read();
    test_round_robin();
    test_back_to_back();
    test_unmapped();
    test_reset_inflight();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
